// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage.
// funct3 access sizes, FSM states and timeout counter width.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Wide enough for any timeout up to 255 cycles.
  localparam int TO_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/load_formatter.sv
// Picks the byte/half/word out of a memory read word
// and sign- or zero-extends it according to funct3.
module load_formatter
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = rdata[{addr, 3'b000} +: 8];
  assign w_half = rdata[{addr[1], 4'b0000} +: 16];

  always_comb begin
    result = '0;
    case (funct3)
      F3_B:    result = {{24{w_byte[7]}}, w_byte};
      F3_BU:   result = {24'b0, w_byte};
      F3_H:    result = {{16{w_half[15]}}, w_half};
      F3_HU:   result = {16'b0, w_half};
      F3_W:    result = rdata;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: runs RISC-V loads/stores over a req/ready/rvalid
// data-memory handshake, stalling the core while an access is in flight.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       store_data,
  input  logic [2:0]        funct3,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              done,
  output logic              access_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam logic [TO_CNT_W-1:0] TO_LAST =
    TO_CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [2:0]          r_funct3;
  logic                r_we;
  logic [TO_CNT_W-1:0] r_cnt;
  logic                r_err_pending;
  logic [31:0]         r_load_data;

  logic        w_start;
  logic        w_both;
  logic        w_misalign;
  logic        w_illegal;
  logic        w_legal;
  logic        w_expired;
  logic [3:0]  w_be;
  logic [31:0] w_lane;
  logic [31:0] w_fmt;

  assign w_start   = mem_read ^ mem_write;
  assign w_both    = mem_read & mem_write;
  assign w_expired = (r_cnt == TO_LAST);

  // Legality of the instruction presented in IDLE.
  always_comb begin
    w_misalign = 1'b0;
    w_illegal  = 1'b0;
    if (mem_read) begin
      case (funct3)
        F3_H, F3_HU: w_misalign = alu_result[0];
        F3_W:        w_misalign = |alu_result[1:0];
        F3_B, F3_BU: w_misalign = 1'b0;
        default:     w_illegal  = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B:    w_misalign = 1'b0;
        F3_H:    w_misalign = alu_result[0];
        F3_W:    w_misalign = |alu_result[1:0];
        default: w_illegal  = 1'b1;
      endcase
    end
  end

  assign w_legal = w_start & ~w_misalign & ~w_illegal;

  // Store lanes: data replicated so any byte enable sees the value.
  always_comb begin
    w_be   = 4'b1111;
    w_lane = r_wdata;
    case (r_funct3)
      F3_B: begin
        w_be   = 4'b0001 << r_addr[1:0];
        w_lane = {4{r_wdata[7:0]}};
      end
      F3_H: begin
        w_be   = r_addr[1] ? 4'b1100 : 4'b0011;
        w_lane = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be   = 4'b1111;
        w_lane = r_wdata;
      end
    endcase
  end

  load_formatter u_fmt (
    .rdata  (mem_rdata),
    .addr   (r_addr[1:0]),
    .funct3 (r_funct3),
    .result (w_fmt)
  );

  always_comb begin
    w_next     = r_state;
    stall      = 1'b0;
    done       = 1'b0;
    access_err = 1'b0;
    load_data  = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = '0;
    mem_wdata  = '0;
    unique case (r_state)
      IDLE: begin
        stall      = w_legal;
        access_err = w_both | (w_start & ~w_legal);
        if (w_legal) w_next = REQ;
      end
      REQ: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = r_we;
        mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
        mem_be    = w_be;
        mem_wdata = w_lane;
        if (mem_ready) w_next = r_we ? DONE : WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (mem_rvalid || w_expired) w_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        access_err = r_err_pending;
        load_data  = r_load_data;
        w_next     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_funct3      <= '0;
      r_we          <= 1'b0;
      r_cnt         <= '0;
      r_err_pending <= 1'b0;
      r_load_data   <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: begin
          if (w_legal) begin
            r_addr        <= alu_result[ADDR_W-1:0];
            r_wdata       <= store_data;
            r_funct3      <= funct3;
            r_we          <= mem_write;
            r_err_pending <= 1'b0;
            r_load_data   <= '0;
          end
        end
        REQ: begin
          if (mem_ready) r_cnt <= '0;
        end
        WAIT: begin
          // rvalid on the expiry cycle still wins over the abort
          if (mem_rvalid) begin
            r_load_data <= w_fmt;
          end else if (w_expired) begin
            r_load_data   <= '0;
            r_err_pending <= 1'b1;
          end else begin
            r_cnt <= r_cnt + TO_CNT_W'(1);
          end
        end
        DONE: begin
          r_err_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a configurable
// memory responder (ready delay, rvalid on/off).
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [2:0]  funct3;
  logic        mem_read;
  logic        mem_write;
  logic        stall;
  logic [31:0] load_data;
  logic        done;
  logic        access_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int          cfg_dly = 0;
  logic        cfg_rvalid = 1'b1;
  logic [31:0] cfg_rdata = '0;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct packed {
    logic        done;
    logic        err;
    logic [31:0] ld;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_result (alu_result),
    .store_data (store_data),
    .funct3     (funct3),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .stall      (stall),
    .load_data  (load_data),
    .done       (done),
    .access_err (access_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] fmt_model(input logic [2:0] f3,
                                            input logic [1:0] off,
                                            input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * off);
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'b0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'b0, s[15:0]};
      default: return w;
    endcase
  endfunction

  // Memory responder: ready after cfg_dly request cycles,
  // rvalid the cycle after a read handshake.
  initial begin
    int   req_cnt;
    logic hs;
    req_cnt = 0;
    forever begin
      @(negedge clk);
      hs = mem_req & mem_ready & ~mem_we;
      @(posedge clk);
      #1;
      mem_rvalid = hs & cfg_rvalid;
      mem_rdata  = cfg_rdata;
      if (mem_req) begin
        if (req_cnt >= cfg_dly) begin
          mem_ready = 1'b1;
          req_cnt   = 0;
        end else begin
          mem_ready = 1'b0;
          req_cnt++;
        end
      end else begin
        mem_ready = 1'b0;
        req_cnt   = 0;
      end
    end
  end

  // Scoreboard consumer: every done/err pulse pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done || access_err) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected", {30'b0, done, access_err}, 32'h0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_flags", {30'b0, done, access_err}, {30'b0, e.done, e.err});
        chk("sb_ldata", load_data, e.ld);
      end
    end
  end

  task automatic run_op(input string tag,
                        input logic rd, input logic wr,
                        input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input int dly, input logic rv,
                        input logic [31:0] rdata,
                        input logic e_done, input logic e_err,
                        input logic [31:0] e_ld,
                        input int e_stall, input int e_req,
                        input logic [3:0] e_be,
                        input logic [31:0] e_wd);
    int   n_stall;
    int   n_req;
    logic fin;
    cfg_dly    = dly;
    cfg_rvalid = rv;
    cfg_rdata  = rdata;
    @(posedge clk);
    #1;
    sb_q.push_back('{done: e_done, err: e_err, ld: e_ld});
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    alu_result = a;
    store_data = sd;
    n_stall = 0;
    n_req   = 0;
    fin     = 1'b0;
    for (int c = 0; c < 100 && !fin; c++) begin
      @(negedge clk);
      if (stall) n_stall++;
      if (mem_req) begin
        n_req++;
        chk({tag, "_addr"}, mem_addr, a & 32'hFFFF_FFFC);
        chk({tag, "_we"}, {31'b0, mem_we}, {31'b0, wr});
        if (wr) begin
          chk({tag, "_be"}, {28'b0, mem_be}, {28'b0, e_be});
          chk({tag, "_wdata"}, mem_wdata, e_wd);
        end
      end
      if (done || access_err) fin = 1'b1;
      @(posedge clk);
      #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
    chk({tag, "_finished"}, {31'b0, fin}, 32'h1);
    chk({tag, "_stall_cycles"}, n_stall, e_stall);
    chk({tag, "_req_cycles"}, n_req, e_req);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3s [5];
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] a;
    logic [31:0] rw;
    f3s = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
    rst        = 1'b1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    funct3     = '0;
    alu_result = '0;
    store_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_err", {31'b0, access_err}, 32'h0);
    chk("rst_req", {31'b0, mem_req}, 32'h0);
    chk("rst_ldata", load_data, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_be", {28'b0, mem_be}, 32'h0);

    run_op("lw10", 1, 0, F3_W, 32'h10, 0, 0, 1, 32'hDEADBEEF,
           1, 0, 32'hDEADBEEF, 3, 1, 4'hF, 0);
    run_op("lb13", 1, 0, F3_B, 32'h13, 0, 0, 1, 32'h80FF_0000,
           1, 0, 32'hFFFF_FF80, 3, 1, 4'hF, 0);
    run_op("lbu13", 1, 0, F3_BU, 32'h13, 0, 0, 1, 32'h80FF_0000,
           1, 0, 32'h0000_0080, 3, 1, 4'hF, 0);
    run_op("lh12", 1, 0, F3_H, 32'h12, 0, 1, 1, 32'h80FF_0000,
           1, 0, 32'hFFFF_80FF, 4, 2, 4'hF, 0);
    run_op("lhu02", 1, 0, F3_HU, 32'h02, 0, 0, 1, 32'h8765_1234,
           1, 0, 32'h0000_8765, 3, 1, 4'hF, 0);
    run_op("sh22", 0, 1, F3_H, 32'h22, 32'h1234_ABCD, 3, 1, 0,
           1, 0, 0, 5, 4, 4'b1100, 32'hABCD_ABCD);
    run_op("sb21", 0, 1, F3_B, 32'h21, 32'h0000_00EF, 0, 1, 0,
           1, 0, 0, 2, 1, 4'b0010, 32'hEFEF_EFEF);
    run_op("sw30", 0, 1, F3_W, 32'h30, 32'hCAFE_F00D, 1, 1, 0,
           1, 0, 0, 3, 2, 4'b1111, 32'hCAFE_F00D);
    run_op("lw02", 1, 0, F3_W, 32'h02, 0, 0, 1, 0,
           0, 1, 0, 0, 0, 4'hF, 0);
    run_op("sh01", 0, 1, F3_H, 32'h01, 32'h55, 0, 1, 0,
           0, 1, 0, 0, 0, 4'hF, 0);
    run_op("ld011", 1, 0, 3'b011, 32'h08, 0, 0, 1, 0,
           0, 1, 0, 0, 0, 4'hF, 0);
    run_op("st100", 0, 1, 3'b100, 32'h08, 0, 0, 1, 0,
           0, 1, 0, 0, 0, 4'hF, 0);
    run_op("lw_to", 1, 0, F3_W, 32'h40, 0, 0, 0, 32'h1111_1111,
           1, 1, 0, 2 + TO, 1, 4'hF, 0);
    run_op("lw_after", 1, 0, F3_W, 32'h44, 0, 0, 1, 32'h0BAD_F00D,
           1, 0, 32'h0BAD_F00D, 3, 1, 4'hF, 0);

    for (int i = 0; i < 8; i++) begin
      f3  = f3s[$urandom_range(0, 4)];
      off = 2'($urandom_range(0, 3));
      if (f3 == F3_H || f3 == F3_HU) off = off & 2'b10;
      if (f3 == F3_W) off = 2'b00;
      a  = {22'b0, 8'($urandom_range(0, 255)), off};
      rw = $urandom;
      run_op("rand_ld", 1, 0, f3, a, 0, 0, 1, rw,
             1, 0, fmt_model(f3, off, rw), 3, 1, 4'hF, 0);
    end

    // Reset while waiting for read data: dropped without done.
    cfg_dly    = 0;
    cfg_rvalid = 1'b0;
    @(posedge clk);
    #1;
    mem_read   = 1'b1;
    funct3     = F3_W;
    alu_result = 32'h50;
    @(posedge clk);
    #1 mem_read = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rw_wait_stall", {31'b0, stall}, 32'h1);
    chk("rw_wait_req", {31'b0, mem_req}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rw_stall", {31'b0, stall}, 32'h0);
    chk("rw_req", {31'b0, mem_req}, 32'h0);
    chk("rw_done", {31'b0, done}, 32'h0);
    chk("rw_err", {31'b0, access_err}, 32'h0);
    chk("rw_ldata", load_data, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_op("both", 1, 1, F3_W, 32'h0, 0, 0, 1, 0,
           0, 1, 0, 0, 0, 4'hF, 0);

    repeat (3) @(posedge clk);
    chk("sb_drained", sb_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory stage directly downstream of the ALU.
- Takes the ALU result as the effective address and rs2 data as store data; performs RISC-V lb/lh/lw/lbu/lhu/sb/sh/sw through a req/ready/rvalid data-memory handshake.
- Stalls the core while an access is in flight.
- Returns sign/zero-extended load data to writeback and flags misaligned, illegal or timed-out accesses.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in WAIT for mem_rvalid before the bus-error abort; legal range 1..255.
- ADDR_W, 32: address width; the address is taken from alu_result[ADDR_W-1:0].

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- alu_result  in  32  effective address from the ALU
- store_data  in  32  rs2 value for stores
- funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- mem_read  in  1  load instruction present
- mem_write  in  1  store instruction present
- stall  out  1  hold PC and pipeline this cycle
- load_data  out  32  extended load result, valid while done=1
- done  out  1  one-cycle pulse: access complete
- access_err  out  1  one-cycle pulse: misaligned, illegal or timeout
- mem_req  out  1  request to data memory
- mem_we  out  1  write enable, qualified by mem_req
- mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
- mem_wdata  out  32  store data replicated into lanes
- mem_be  out  4  byte enables
- mem_ready  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word

Behaviour:
- Reset: state=IDLE; all outputs 0; internal address, data, funct3 and timeout counter registers cleared.
- start = (mem_read ^ mem_write) in IDLE. Both asserted together: access_err pulse, no bus access, no stall.
- Legality check, evaluated combinationally in IDLE:
  - Misaligned: h/hu/sh with addr[0]=1; w/sw with addr[1:0]!=0.
  - Illegal: load funct3 in {011,110,111}; store funct3 > 010.
  - Either case: access_err=1 that cycle, stall=0, no transition, load_data=0.
- stall = (IDLE & legal start) | REQ | WAIT. stall is 0 in DONE, so the instruction retires at the end of the DONE cycle.
- IDLE, legal start: latch addr, store_data, funct3, we; go to REQ next cycle.
- REQ:
  - mem_req=1; addr, we, be and wdata held stable until mem_ready.
  - mem_req & mem_ready & we -> DONE.
  - mem_req & mem_ready & !we -> WAIT; clear the counter.
- WAIT:
  - mem_rvalid -> capture the formatted mem_rdata into load_data; go to DONE.
  - Otherwise the counter increments. When counter == TIMEOUT_CYCLES-1 with no rvalid -> load_data=0, set err_pending, go to DONE.
  - rvalid arriving in the same cycle as expiry wins: no error.
- DONE: done=1 for one cycle; access_err=1 if err_pending; next state IDLE. mem_read/mem_write in DONE are ignored, because they still belong to the retiring instruction.
- Store byte enables: sb -> be = 1<<addr[1:0], wdata = {4{sd[7:0]}}; sh -> be = addr[1] ? 1100 : 0011, wdata = {2{sd[15:0]}}; sw -> be = 1111, wdata = sd.
- Load format:
  - Select the byte mem_rdata[8*addr[1:0]+:8] or the half mem_rdata[16*addr[1]+:16].
  - b/h sign-extend; bu/hu zero-extend; w passes through.
- mem_ready asserted while mem_req=0 is ignored. mem_rvalid outside WAIT is ignored.
- rst in any state returns to IDLE next edge:
  - An in-flight request is dropped with no done pulse.
  - mem_req deasserts immediately after the edge.
- Latency with a zero-wait memory (ready in REQ, rvalid the next cycle):
  - Load: 3 cycles stalled (IDLE, REQ, WAIT), plus DONE.
  - Store: 2 cycles stalled, plus DONE.

Decomposition:
- Package mem_pkg holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encoding: IDLE, REQ, WAIT, DONE.
  - Timeout counter width localparam.
- One combinational sub-module, load_formatter (inputs rdata, addr[1:0], funct3; output 32-bit result), reusable by a future MMIO path.
- Store lane and byte-enable logic stays inline.

Test Plan:
- lw at 0x0000_0010, memory ready=1 in REQ, rvalid next cycle with rdata=0xDEADBEEF -> stall high 3 cycles, then done=1 and load_data=0xDEADBEEF; mem_addr=0x10.
- lb at 0x13 and lbu at 0x13, rdata=0x80FF_0000 -> load_data=0xFFFF_FF80 and 0x0000_0080 respectively.
- sh at 0x22, store_data=0x1234_ABCD, ready delayed 3 cycles -> mem_req/be=1100/wdata=0xABCD_ABCD held stable for 4 cycles; done 1 cycle after ready.
- lw at 0x02, and sh at 0x01 -> access_err pulse in the same cycle, mem_req never asserts, stall=0.
- lw with rvalid never returned, TIMEOUT_CYCLES=16 -> 16 cycles in WAIT, then done=1, access_err=1, load_data=0; next instruction proceeds.
- rst asserted while in WAIT; then mem_read and mem_write both high -> IDLE next edge with all outputs 0 and no done pulse; then access_err pulse with no request.
